single_bin_corr_ctrl: RTL and testbench

SINGLE_BIN_CORR_CTRL -- requirements
Module: single_bin_corr_ctrl

---
 rtl/single_bin_corr_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_single_bin_corr_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_bin_corr_ctrl.sv
// ---------------------------------------------------------------------------
// SingleBinCorrCtrl -- capture controller for a single-bin cross-correlator.
//
// On arm the block latches the accumulation length and frame budget, restarts
// the correlator, throws away the first (partial) accumulation, and then
// copies each following correlator result into a one-deep output register
// with a valid/ready handshake. Results that arrive while the output register
// is still full and not being drained are dropped and counted as overruns.
// Capture ends when the frame budget is used up (num_frames != 0) or on stop.
// The controller then waits for the output register to empty, pulses done and
// returns to idle.
//
// Optional feature macro: SINGLE_BIN_CORR_CTRL_OVERRUN_CNT_EN
//   defined   : overrun_cnt counts dropped frames (saturating)
//   undefined : overrun_cnt is tied to 0, no counter is built
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   arm, stop                     one-cycle start / abort pulses
//   num_frames                    frames to capture, 0 = continuous
//   acc_len_cfg / acc_len         requested / applied accumulation length
//   corr_rst                      one-cycle correlator restart pulse
//   aa, bb, ab_re, ab_im          correlator result words
//   corr_valid                    correlator result strobe
//   m_aa, m_bb, m_ab_re, m_ab_im  captured frame
//   m_valid, m_ready              output handshake
//   frame_cnt, overrun_cnt        saturating capture / drop counters
//   busy, done                    activity flag, end-of-capture pulse
// ---------------------------------------------------------------------------
module single_bin_corr_ctrl #(
    parameter int DOUT_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  num_frames,
    input  logic [31:0]           acc_len_cfg,
    output logic [31:0]           acc_len,
    output logic                  corr_rst,
    input  logic [DOUT_WIDTH-1:0] aa,
    input  logic [DOUT_WIDTH-1:0] bb,
    input  logic [DOUT_WIDTH-1:0] ab_re,
    input  logic [DOUT_WIDTH-1:0] ab_im,
    input  logic                  corr_valid,
    output logic [DOUT_WIDTH-1:0] m_aa,
    output logic [DOUT_WIDTH-1:0] m_bb,
    output logic [DOUT_WIDTH-1:0] m_ab_re,
    output logic [DOUT_WIDTH-1:0] m_ab_im,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  overrun_cnt,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        DISCARD,
        RUN,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             accLen_q, accLen_d;
    logic [CNT_WIDTH-1:0]    numFrames_q, numFrames_d;
    logic [CNT_WIDTH-1:0]    frameCnt_q, frameCnt_d;
    logic                    mValid_q, mValid_d;
    logic [DOUT_WIDTH-1:0]   mAa_q, mBb_q, mAbRe_q, mAbIm_q;
    logic                    load;
    logic                    clearCnt;

    // Next-state and control decode. A frame is loaded when the output
    // register is empty or is being emptied in this very cycle, so a
    // back-to-back stream with m_ready high never loses a frame. The frame
    // budget is checked against the post-load count so the FSM leaves RUN on
    // the same edge that captures the last frame.
    always_comb begin
        state_d     = state_q;
        accLen_d    = accLen_q;
        numFrames_d = numFrames_q;
        frameCnt_d  = frameCnt_q;
        load        = 1'b0;
        clearCnt    = 1'b0;
        corr_rst    = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    accLen_d    = acc_len_cfg;
                    numFrames_d = num_frames;
                    frameCnt_d  = '0;
                    clearCnt    = 1'b1;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                corr_rst = 1'b1;
                state_d  = stop ? DRAIN : DISCARD;
            end
            DISCARD: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (corr_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (corr_valid && (!mValid_q || m_ready)) begin
                    load = 1'b1;
                    if (frameCnt_q != '1) begin
                        frameCnt_d = frameCnt_q + CNT_WIDTH'(1);
                    end
                end
                if (stop) begin
                    state_d = DRAIN;
                end else if ((numFrames_q != '0) && (frameCnt_d == numFrames_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!mValid_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register occupancy: a load always wins over a drain.
    always_comb begin
        mValid_d = mValid_q;
        if (mValid_q && m_ready) begin
            mValid_d = 1'b0;
        end
        if (load) begin
            mValid_d = 1'b1;
        end
    end

    // State, configuration and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            accLen_q    <= '0;
            numFrames_q <= '0;
            frameCnt_q  <= '0;
            mValid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            accLen_q    <= accLen_d;
            numFrames_q <= numFrames_d;
            frameCnt_q  <= frameCnt_d;
            mValid_q    <= mValid_d;
        end
    end

    // Captured frame: plain copies of the correlator words, held between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mAa_q   <= '0;
            mBb_q   <= '0;
            mAbRe_q <= '0;
            mAbIm_q <= '0;
        end else if (load) begin
            mAa_q   <= aa;
            mBb_q   <= bb;
            mAbRe_q <= ab_re;
            mAbIm_q <= ab_im;
        end
    end

`ifdef SINGLE_BIN_CORR_CTRL_OVERRUN_CNT_EN
    logic                 drop;
    logic [CNT_WIDTH-1:0] overrunCnt_q;

    // A frame is dropped when it arrives in RUN while the held frame is not
    // being taken; this mirrors the load condition above.
    assign drop = (state_q == RUN) && corr_valid && mValid_q && !m_ready;

    // Saturating overrun counter, cleared on arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrunCnt_q <= '0;
        end else if (clearCnt) begin
            overrunCnt_q <= '0;
        end else if (drop && (overrunCnt_q != '1)) begin
            overrunCnt_q <= overrunCnt_q + CNT_WIDTH'(1);
        end
    end

    assign overrun_cnt = overrunCnt_q;
`else
    logic unusedClearCnt;

    assign unusedClearCnt = clearCnt;
    assign overrun_cnt    = '0;
`endif

    assign acc_len   = accLen_q;
    assign frame_cnt = frameCnt_q;
    assign m_valid   = mValid_q;
    assign m_aa      = mAa_q;
    assign m_bb      = mBb_q;
    assign m_ab_re   = mAbRe_q;
    assign m_ab_im   = mAbIm_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_single_bin_corr_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for single_bin_corr_ctrl. Stimulus pushes every frame it expects
// to see on the output into a queue; a monitor on the falling edge pops and
// compares on each m_valid&m_ready transfer, and also counts corr_rst and
// done pulses. Counter widths are reduced so saturation is reachable quickly.
// Overrun expectations follow SINGLE_BIN_CORR_CTRL_OVERRUN_CNT_EN.
// ---------------------------------------------------------------------------
module tb_single_bin_corr_ctrl;

    localparam int DW = 32;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] aa;
        logic [DW-1:0] bb;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } frame_t;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          arm         = 1'b0;
    logic          stop        = 1'b0;
    logic [CW-1:0] num_frames  = '0;
    logic [31:0]   acc_len_cfg = '0;
    logic [31:0]   acc_len;
    logic          corr_rst;
    logic [DW-1:0] aa          = '0;
    logic [DW-1:0] bb          = '0;
    logic [DW-1:0] ab_re       = '0;
    logic [DW-1:0] ab_im       = '0;
    logic          corr_valid  = 1'b0;
    logic [DW-1:0] m_aa, m_bb, m_ab_re, m_ab_im;
    logic          m_valid;
    logic          m_ready     = 1'b1;
    logic [CW-1:0] frame_cnt, overrun_cnt;
    logic          busy, done;

    int     errors      = 0;
    int     checks      = 0;
    int     corrRstSeen = 0;
    int     doneSeen    = 0;
    frame_t expQ[$];

    single_bin_corr_ctrl #(.DOUT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop),
        .num_frames(num_frames), .acc_len_cfg(acc_len_cfg), .acc_len(acc_len),
        .corr_rst(corr_rst), .aa(aa), .bb(bb), .ab_re(ab_re), .ab_im(ab_im),
        .corr_valid(corr_valid), .m_aa(m_aa), .m_bb(m_bb), .m_ab_re(m_ab_re),
        .m_ab_im(m_ab_im), .m_valid(m_valid), .m_ready(m_ready),
        .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counting and scoreboard comparison of each transfer.
    always @(negedge clk) begin
        if (corr_rst) corrRstSeen++;
        if (done) doneSeen++;
        if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected frame", {m_aa, m_bb, m_ab_re, m_ab_im}, 128'h0);
            end else begin
                frame_t f;
                f = expQ.pop_front();
                checkOutput("frame", {m_aa, m_bb, m_ab_re, m_ab_im}, f);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic frame_t mk(input int k);
        frame_t f;
        f.aa = 32'hA000_0000 + DW'(k);
        f.bb = 32'hB000_0000 + DW'(k);
        f.re = 32'hFFFF_FFFF - DW'(k);
        f.im = 32'h0123_4500 + DW'(k);
        return f;
    endfunction

    task automatic applyStimulus(input frame_t f, input bit capture);
        aa = f.aa; bb = f.bb; ab_re = f.re; ab_im = f.im;
        corr_valid = 1'b1;
        if (capture) expQ.push_back(f);
        step(1);
        corr_valid = 1'b0;
    endtask

    task automatic doArm(input logic [CW-1:0] n, input logic [31:0] len);
        num_frames = n; acc_len_cfg = len; arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(3);
    endtask

    task automatic doStop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (busy && n < maxCycles) begin
            step(1);
            n++;
        end
        checkOutput("back to idle", busy, 0);
    endtask

    initial begin
        int d0, r0;
        logic [CW-1:0] expOvr;
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0, r0;
        logic [CW-1:0] expOvr;

        // Reset state
        step(2);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset corr_rst", corr_rst, 0);
        checkOutput("reset acc_len", acc_len, 0);
        checkOutput("reset counters", {frame_cnt, overrun_cnt}, 0);
        checkOutput("reset data", {m_aa, m_bb, m_ab_re, m_ab_im}, 0);
        rst = 1'b0;
        step(2);

        // Fixed budget of 3 frames, first result discarded, extra ignored
        d0 = doneSeen; r0 = corrRstSeen;
        m_ready = 1'b1;
        doArm(3'd3, 32'd10);
        checkOutput("acc_len latched", acc_len, 10);
        applyStimulus(mk(0), 0); step(3);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(mk(k), 1); step(3);
        end
        applyStimulus(mk(4), 0);
        waitIdle(20);
        checkOutput("t1 corr_rst pulses", corrRstSeen - r0, 1);
        checkOutput("t1 done pulses", doneSeen - d0, 1);
        checkOutput("t1 frame_cnt", frame_cnt, 3);

        // Stalled output: first frame held, later ones dropped
        d0 = doneSeen;
        m_ready = 1'b0;
        doArm(3'd0, 32'd20);
        applyStimulus(mk(10), 0); step(2);
        applyStimulus(mk(11), 1); step(2);
        applyStimulus(mk(12), 0); step(2);
        applyStimulus(mk(13), 0); step(2);
        checkOutput("held frame", {m_aa, m_bb, m_ab_re, m_ab_im}, mk(11));
        checkOutput("t2 frame_cnt", frame_cnt, 1);
`ifdef SINGLE_BIN_CORR_CTRL_OVERRUN_CNT_EN
        expOvr = 3'd2;
`else
        expOvr = 3'd0;
`endif
        checkOutput("t2 overrun_cnt", overrun_cnt, expOvr);
        m_ready = 1'b1;
        step(2);
        doStop();
        waitIdle(20);
        checkOutput("t2 done pulses", doneSeen - d0, 1);

        // Back-to-back results while draining: every one loaded, no overrun
        doArm(3'd0, 32'd5);
        applyStimulus(mk(20), 0); step(2);
        applyStimulus(mk(21), 1);
        applyStimulus(mk(22), 1);
        applyStimulus(mk(23), 1);
        step(2);
        checkOutput("t3 frame_cnt", frame_cnt, 3);
        checkOutput("t3 overrun_cnt", overrun_cnt, 0);
        doStop();
        waitIdle(20);

        // Continuous capture, stop while the last frame is still held
        d0 = doneSeen;
        doArm(3'd0, 32'd7);
        applyStimulus(mk(30), 0); step(2);
        for (int k = 31; k <= 34; k++) begin
            applyStimulus(mk(k), 1); step(2);
        end
        m_ready = 1'b0;
        applyStimulus(mk(35), 1); step(2);
        doStop();
        step(3);
        checkOutput("drain waits busy", busy, 1);
        checkOutput("drain waits no done", doneSeen - d0, 0);
        checkOutput("t4 frame_cnt", frame_cnt, 5);
        m_ready = 1'b1;
        waitIdle(20);
        checkOutput("t4 done pulses", doneSeen - d0, 1);

        // Reset in RUN with a held frame
        m_ready = 1'b0;
        doArm(3'd0, 32'd9);
        applyStimulus(mk(40), 0); step(2);
        applyStimulus(mk(41), 0); step(2);
        d0 = doneSeen;
        rst = 1'b1;
        #1;
        checkOutput("rst m_valid/busy", {m_valid, busy, done, corr_rst}, 0);
        checkOutput("rst data", {m_aa, m_bb, m_ab_re, m_ab_im}, 0);
        checkOutput("rst acc_len/counts", {acc_len, frame_cnt, overrun_cnt}, 0);
        step(1);
        rst = 1'b0;
        step(2);
        checkOutput("rst no done", doneSeen - d0, 0);
        m_ready = 1'b1;
        doArm(3'd1, 32'd9);
        applyStimulus(mk(42), 0); step(2);
        applyStimulus(mk(43), 1);
        waitIdle(20);
        checkOutput("restart frame_cnt", frame_cnt, 1);
        checkOutput("restart done", doneSeen - d0, 1);

        // Arm and new config ignored in RUN; stop coinciding with a result
        d0 = doneSeen;
        doArm(3'd0, 32'd10);
        applyStimulus(mk(50), 0); step(2);
        applyStimulus(mk(51), 1); step(2);
        acc_len_cfg = 32'd99; num_frames = 3'd5; arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(1);
        checkOutput("acc_len held", acc_len, 10);
        checkOutput("arm ignored frame_cnt", frame_cnt, 1);
        checkOutput("arm ignored busy", busy, 1);
        stop = 1'b1;
        applyStimulus(mk(52), 1);
        stop = 1'b0;
        checkOutput("stop+valid frame_cnt", frame_cnt, 2);
        waitIdle(20);
        checkOutput("t6 done pulses", doneSeen - d0, 1);

        // Stop in IDLE ignored, stop in FLUSH aborts cleanly
        doStop();
        step(1);
        checkOutput("idle stop ignored", busy, 0);
        d0 = doneSeen; r0 = corrRstSeen;
        num_frames = 3'd2; acc_len_cfg = 32'd3; arm = 1'b1;
        step(1);
        arm = 1'b0;
        doStop();
        waitIdle(10);
        checkOutput("flush stop corr_rst", corrRstSeen - r0, 1);
        checkOutput("flush stop done", doneSeen - d0, 1);
        checkOutput("flush stop frame_cnt", frame_cnt, 0);

        // Saturation of both counters
        doArm(3'd0, 32'd4);
        applyStimulus(mk(60), 0); step(2);
        for (int k = 61; k <= 69; k++) begin
            applyStimulus(mk(k), 1); step(2);
        end
        checkOutput("frame_cnt saturates", frame_cnt, 7);
        m_ready = 1'b0;
        applyStimulus(mk(70), 1); step(2);
        for (int k = 71; k <= 79; k++) begin
            applyStimulus(mk(k), 0); step(1);
        end
`ifdef SINGLE_BIN_CORR_CTRL_OVERRUN_CNT_EN
        expOvr = 3'd7;
`else
        expOvr = 3'd0;
`endif
        checkOutput("overrun saturates", overrun_cnt, expOvr);
        checkOutput("sat held frame", {m_aa, m_bb, m_ab_re, m_ab_im}, mk(70));
        m_ready = 1'b1;
        step(2);
        doStop();
        waitIdle(20);

        checkOutput("scoreboard empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
